// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its skid buffer.
package if_fetch_unit_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} fetch_state_e;

  // Redirect targets are always word aligned.
  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
    return {a[WORD_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding slot for a word fetched while decode was frozen.
module if_skid_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  unload_i,
  input  logic                  clear_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic [WORD_WIDTH-1:0] pc_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic [WORD_WIDTH-1:0] pc_o,
  output logic                  valid_o
);
  logic [WORD_WIDTH-1:0] data_q, pc_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding memory read, freeze handling via a skid slot,
// and branch redirects that drain any in-flight request before refetching.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  mem_req,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic                  valid_out
);
  fetch_state_e          state_q;
  logic [WORD_WIDTH-1:0] pc_q, drain_addr_q, instr_q, pc_out_q;
  logic                  valid_q;
  logic [WORD_WIDTH-1:0] pc_plus4, br_target;
  logic                  skid_load, skid_unload;
  logic [WORD_WIDTH-1:0] skid_data, skid_pc;
  logic                  skid_valid;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = word_align(branch_addr);

  always_comb begin
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (!branch_taken) begin
      skid_load   = (state_q == FETCH) && mem_ack && freeze;
      skid_unload = (state_q == STALL) && !freeze && skid_valid;
    end
  end

  if_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (branch_taken),
    .data_i   (mem_rdata),
    .pc_i     (pc_plus4),
    .data_o   (skid_data),
    .pc_o     (skid_pc),
    .valid_o  (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          if (branch_taken) begin
            pc_q    <= br_target;
            valid_q <= 1'b0;
          end
        end
        FETCH: begin
          if (branch_taken) begin
            pc_q    <= br_target;
            valid_q <= 1'b0;
            // Request still in flight: its address must stay on the bus until acked.
            if (!mem_ack) begin
              drain_addr_q <= pc_q;
              state_q      <= DRAIN;
            end
          end else if (mem_ack && !freeze) begin
            instr_q  <= mem_rdata;
            pc_out_q <= pc_plus4;
            valid_q  <= 1'b1;
            pc_q     <= pc_plus4;
          end else if (mem_ack) begin
            pc_q    <= pc_plus4;
            state_q <= STALL;
          end else if (!freeze) begin
            valid_q <= 1'b0;
          end
        end
        STALL: begin
          if (branch_taken) begin
            pc_q    <= br_target;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (skid_unload) begin
            instr_q  <= skid_data;
            pc_out_q <= skid_pc;
            valid_q  <= 1'b1;
            state_q  <= FETCH;
          end
        end
        DRAIN: begin
          valid_q <= 1'b0;
          if (branch_taken) pc_q <= br_target;
          if (mem_ack) state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req         = (state_q == FETCH) || (state_q == DRAIN);
  assign mem_addr        = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign valid_out       = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench: acks push expected words into a queue, a negedge monitor pops them.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instruction_out, pc_out;
  logic        valid_out;

  typedef struct {logic [31:0] ins; logic [31:0] pc;} exp_t;
  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic frz_last = 1'b0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction_out(instruction_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack the current request; keep=1 means the word must eventually reach decode.
  task automatic ack(input bit keep);
    exp_t e;
    chk("ack_req", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hE000_0000 + mem_addr;
    if (keep) begin
      e.ins = mem_rdata;
      e.pc  = mem_addr + 32'd4;
      sbq.push_back(e);
    end
    tick();
    mem_ack = 1'b0;
  endtask

  // With freeze low at an edge, a live output afterwards is always a freshly loaded word.
  always @(posedge clk) frz_last = freeze;

  always @(negedge clk) begin
    if (valid_out && !frz_last) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h/%h want none", instruction_out, pc_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_ins", instruction_out, e.ins);
        chk("out_pc", pc_out, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_ins", instruction_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    tick();
    chk("start_addr", mem_addr, 32'h0);

    // Back-to-back fetch
    ack(1); chk("addr4", mem_addr, 32'h4);
    ack(1); chk("addr8", mem_addr, 32'h8);
    ack(1); chk("addrC", mem_addr, 32'hC);
    tick();
    chk("bubble", {31'd0, valid_out}, 32'd0);

    // Freeze while the word at 0x10 is acked
    ack(1); chk("addr10", mem_addr, 32'h10);
    freeze = 1'b1;
    ack(1);
    tick(); tick();
    chk("frz_ins", instruction_out, 32'hE000_000C);
    chk("frz_pc", pc_out, 32'h10);
    chk("frz_req", {31'd0, mem_req}, 32'd0);
    freeze = 1'b0;
    tick();
    chk("rel_ins", instruction_out, 32'hE000_0010);
    chk("rel_pc", pc_out, 32'h14);
    chk("rel_addr", mem_addr, 32'h14);

    // Branch while the request at 0x20 is pending
    ack(1); ack(1); ack(1);
    chk("addr20", mem_addr, 32'h20);
    branch_taken = 1'b1; branch_addr = 32'h100;
    tick();
    branch_taken = 1'b0;
    chk("drain_valid", {31'd0, valid_out}, 32'd0);
    chk("drain_addr", mem_addr, 32'h20);
    tick();
    chk("drain_hold", mem_addr, 32'h20);
    ack(0);
    chk("post_drain_valid", {31'd0, valid_out}, 32'd0);
    chk("target_addr", mem_addr, 32'h100);
    ack(1);

    // Branch + freeze + ack together; unaligned target
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h203;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    freeze = 1'b0; branch_taken = 1'b0; mem_ack = 1'b0;
    chk("bf_valid", {31'd0, valid_out}, 32'd0);
    chk("bf_addr", mem_addr, 32'h200);
    ack(1);

    // PC wrap
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC; mem_ack = 1'b1;
    tick();
    branch_taken = 1'b0; mem_ack = 1'b0;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    ack(1);
    chk("wrap_addr1", mem_addr, 32'h0);

    // Reset with a pending request and a late ack
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_ins", instruction_out, 32'd0);
    chk("mid_rst_pc", pc_out, 32'd0);
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0000;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, valid_out}, 32'd0);
    chk("late_ack_ins", instruction_out, 32'd0);
    chk("restart_addr", mem_addr, 32'h0);
    ack(1);

    // Branch inside DRAIN retargets
    branch_taken = 1'b1; branch_addr = 32'h300;
    tick();
    branch_addr = 32'h400;
    tick();
    branch_taken = 1'b0;
    chk("redrain_addr", mem_addr, 32'h4);
    ack(0);
    chk("retarget_addr", mem_addr, 32'h400);
    ack(1);

    tick(); tick();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
